// File: rtl/reg_writeback_queue.sv
// ============================================================================
// reg_writeback_queue
// ----------------------------------------------------------------------------
// The write-side producer for the 4 x 8-bit general register file (AX..DX).
// Register-write requests arrive from the execute stage over a valid/ready
// handshake. They are held in an in-order FIFO and drained at most one per
// cycle into a registered output stage. That stage drives the register file's
// one-hot write enables and its broadcast write data. Readers can see
// in-flight data through the pending flags and the forwarding lookup.
//
// Ports
//   clk           in   clock, all state on rising edge
//   rst_n         in   asynchronous reset, active-low
//   req_valid_i   in   write request valid
//   req_ready_o   out  queue can accept (!full, 0 while in reset)
//   req_addr_i    in   target register (0=AX 1=BX 2=CX 3=DX)
//   req_data_i    in   data to write
//   drain_en_i    in   register file write port available this cycle
//   flush_i       in   synchronous discard of all queued entries
//   wr_en_o       out  registered one-hot write enable, bit i -> register i
//   wr_data_o     out  registered write data, broadcast to all registers
//   pending_o     out  bit i: a queued or output-stage write targets reg i
//   fwd_addr_i    in   forwarding lookup address
//   fwd_hit_o     out  an in-flight write to fwd_addr_i exists
//   fwd_data_o    out  data of the youngest such write, 0 when no hit
//   count_o       out  FIFO occupancy, output stage excluded
// ============================================================================
module reg_writeback_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4,
    localparam int NREG  = 2 ** ADDR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic              drain_en_i,
    input  logic              flush_i,
    output logic [NREG-1:0]   wr_en_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [NREG-1:0]   pending_o,
    input  logic [ADDR_W-1:0] fwd_addr_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [CNT_W-1:0]  count_o
);

    // FIFO storage. Storage is not reset: only entries inside the
    // [head, head+count) window are ever read.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREG-1:0]   wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic full, empty, push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Ready reflects the current occupancy only; a pop in the same cycle
    // does not open a slot early. Ready is gated by rst_n so it reads 0
    // while reset is held.
    assign req_ready_o = rst_n && !full;
    assign push        = req_valid_i && req_ready_o && !flush_i;
    assign pop         = drain_en_i && !empty && !flush_i;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d    = head_q + PTR_W'(1);
                wr_en_d   = NREG'(1) << addr_mem[head_q];
                wr_data_d = data_mem[head_q];
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= req_addr_i;
            data_mem[tail_q] <= req_data_i;
        end
    end

    // Entries are viewed in age order: slot 0 is the head (oldest) and
    // slot count-1 is the youngest.
    logic              ent_valid [DEPTH];
    logic [ADDR_W-1:0] ent_addr  [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];
    logic [NREG-1:0]   ent_mask  [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign ent_valid[gi] = (CNT_W'(gi) < count_q);
        assign ent_addr[gi]  = addr_mem[head_q + PTR_W'(gi)];
        assign ent_data[gi]  = data_mem[head_q + PTR_W'(gi)];
        assign ent_mask[gi]  = ent_valid[gi] ? (NREG'(1) << ent_addr[gi]) : '0;
    end

    always_comb begin
        pending_o = wr_en_q;
        for (int k = 0; k < DEPTH; k++) begin
            pending_o = pending_o | ent_mask[k];
        end
    end

    // Walk from the oldest source to the youngest, so that each later match
    // overrides an earlier one. The output stage is older than every FIFO
    // entry, and the youngest matching write wins.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (wr_en_q[fwd_addr_i]) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = wr_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && ent_addr[k] == fwd_addr_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = ent_data[k];
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_data_o = wr_data_q;
    assign count_o   = count_q;

endmodule
